// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and bus encodings for the instruction prefetch front end.
// Encodings match the sys_defs.vh values of BUS_NONE, BUS_LOAD and NOOP_INST.
package if_prefetch_queue_pkg;
  localparam logic [1:0]  BUS_NONE  = 2'h0;
  localparam logic [1:0]  BUS_LOAD  = 2'h1;
  localparam logic [31:0] NOOP_INST = 32'h47ff_041f;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bundles the redirect, imem and IF/ID signals of the prefetch front end.
// master = prefetch unit, slave = surrounding pipeline and memory.
interface if_prefetch_queue_if;
  logic        ex_take_branch_out;
  logic [31:0] ex_target_PC_out;
  logic        if_stall;
  logic [31:0] proc2Imem_addr;
  logic [1:0]  proc2Imem_command;
  logic        Imem2proc_ready;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;
  logic        if_valid_inst_out;

  modport master (
    input  ex_take_branch_out, ex_target_PC_out, if_stall,
           Imem2proc_ready, Imem2proc_valid, Imem2proc_data,
    output proc2Imem_addr, proc2Imem_command,
           if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out
  );

  modport slave (
    output ex_take_branch_out, ex_target_PC_out, if_stall,
           Imem2proc_ready, Imem2proc_valid, Imem2proc_data,
    input  proc2Imem_addr, proc2Imem_command,
           if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out
  );
endinterface

// File: rtl/if_prefetch_queue_pf_fifo.sv
// Circular FIFO of fetched {pc, ir} entries; clear wins over push and pop.
module pf_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output fetch_entry_t           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front end: credit-limited in-order fetch issue, a small
// return queue, and redirect handling that discards in-flight responses.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   r_fetch_pc, r_ret_pc;
  logic [OW-1:0] r_outst, r_drop;
  logic [CW-1:0] w_count;
  logic [31:0]   w_target;
  logic          w_full, w_empty, w_redirect, w_issue, w_accept;
  logic          w_resp, w_discard, w_push, w_pop, w_valid;
  fetch_entry_t  w_head, w_new;

  assign w_redirect = bus.ex_take_branch_out;
  assign w_target   = bus.ex_target_PC_out & ~32'h3;

  // Credit rule: queued plus in-flight words never exceed DEPTH, so a response
  // always has a free slot.
  assign w_issue   = !rst && !w_redirect && (int'(r_outst) < MAX_OUTSTANDING)
                     && ((int'(w_count) + int'(r_outst)) < DEPTH);
  assign w_accept  = w_issue && bus.Imem2proc_ready;
  assign w_resp    = bus.Imem2proc_valid;
  assign w_discard = w_resp && (r_drop != '0);
  assign w_push    = w_resp && !w_discard && !w_redirect;
  assign w_valid   = !w_empty && !w_redirect;
  assign w_pop     = w_valid && !bus.if_stall;
  assign w_new     = '{pc: r_ret_pc, ir: bus.Imem2proc_data};

  assign bus.proc2Imem_addr    = r_fetch_pc;
  assign bus.proc2Imem_command = w_issue ? BUS_LOAD : BUS_NONE;
  assign bus.if_valid_inst_out = w_valid;
  assign bus.if_PC_out         = w_valid ? w_head.pc : 32'h0;
  assign bus.if_NPC_out        = w_valid ? (w_head.pc + 32'd4) : 32'h0;
  assign bus.if_IR_out         = w_valid ? w_head.ir : NOOP_INST;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_ret_pc   <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_outst <= r_outst + OW'(w_accept) - OW'(w_resp);
      if (w_redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_target;
        r_ret_pc   <= w_target;
        r_drop     <= r_outst - OW'(w_resp);
      end else begin
        if (w_accept)  r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)    r_ret_pc   <= r_ret_pc + 32'd4;
        if (w_discard) r_drop     <= r_drop - OW'(1);
      end
    end
  end

  a_no_full_push: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst) !(w_resp && (r_outst == '0)));
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Random and directed stimulus against an in-bench memory and an expected
// instruction-stream scoreboard checked by an independent monitor.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_prefetch_queue_if bus();

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_fetch = RPC;
  logic [31:0] prev_addr = 32'h0;
  bit          prev_hold = 1'b0;
  bit          first_req = 1'b0;
  bit          stall_hold = 1'b0;
  int          vecs = 0, errs = 0, cyc = 0, accepts = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, stall_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
    int lat;
    bus.ex_take_branch_out = redir;
    bus.ex_target_PC_out   = tgt;
    bus.if_stall           = stall_hold || ($urandom_range(99) < stall_pct);
    bus.Imem2proc_ready    = ($urandom_range(99) < rdy_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.Imem2proc_valid = 1'b1;
      bus.Imem2proc_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.Imem2proc_valid = 1'b0;
      bus.Imem2proc_data  = $urandom;
    end
    if (redir) begin
      exp_pc_q.delete();
      exp_pc_q.push_back(tgt & ~32'h3);
    end
    while (exp_pc_q.size() < 8) exp_pc_q.push_back(exp_pc_q[$] + 32'd4);
    #1;
    if (redir) chk("cmd_on_redirect", 32'(bus.proc2Imem_command), 32'(BUS_NONE));
    else if (prev_hold) begin
      chk("held_cmd", 32'(bus.proc2Imem_command), 32'(BUS_LOAD));
      chk("held_addr", bus.proc2Imem_addr, prev_addr);
    end
    if (first_req && !redir) begin
      chk("first_cmd_after_reset", 32'(bus.proc2Imem_command), 32'(BUS_LOAD));
      chk("first_addr_after_reset", bus.proc2Imem_addr, RPC);
    end
    first_req = 1'b0;
    prev_hold = (bus.proc2Imem_command == BUS_LOAD) && !bus.Imem2proc_ready;
    prev_addr = bus.proc2Imem_addr;
    if (bus.proc2Imem_command == BUS_LOAD && bus.Imem2proc_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      chk("fetch_addr", bus.proc2Imem_addr, exp_fetch);
      exp_fetch += 32'd4;
      pend.push_back('{addr: bus.proc2Imem_addr, due: cyc + lat});
      chk("outstanding_cap", 32'(pend.size() <= MAXO), 32'd1);
      accepts++;
    end
    if (redir) exp_fetch = tgt & ~32'h3;
    cyc++;
    @(negedge clk);
  endtask

  // Asserted between edges so the outputs must change without a clock.
  task automatic do_reset();
    #3 rst = 1'b1;
    bus.ex_take_branch_out = 1'b0;
    bus.ex_target_PC_out   = 32'h0;
    bus.if_stall           = 1'b0;
    bus.Imem2proc_ready    = 1'b0;
    bus.Imem2proc_valid    = 1'b0;
    bus.Imem2proc_data     = 32'h0;
    #1;
    chk("reset_cmd", 32'(bus.proc2Imem_command), 32'(BUS_NONE));
    chk("reset_addr", bus.proc2Imem_addr, RPC);
    chk("reset_valid", 32'(bus.if_valid_inst_out), 32'd0);
    chk("reset_ir", bus.if_IR_out, NOOP_INST);
    chk("reset_pc", bus.if_PC_out, 32'h0);
    chk("reset_npc", bus.if_NPC_out, 32'h0);
    pend.delete();
    exp_pc_q.delete();
    exp_pc_q.push_back(RPC);
    exp_fetch = RPC;
    prev_hold = 1'b0;
    first_req = 1'b1;
    accepts   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.ex_take_branch_out)
        chk("valid_on_redirect", 32'(bus.if_valid_inst_out), 32'd0);
      else if (!bus.if_valid_inst_out)
        chk("noop_when_empty", bus.if_IR_out, NOOP_INST);
      else begin
        chk("head_pc", bus.if_PC_out, exp_pc_q[0]);
        chk("head_npc", bus.if_NPC_out, exp_pc_q[0] + 32'd4);
        chk("head_ir", bus.if_IR_out, mem_word(exp_pc_q[0]));
        if (!bus.if_stall) void'(exp_pc_q.pop_front());
      end
    end
  end

  initial begin
    bit          rd;
    logic [31:0] tg;
    bus.ex_take_branch_out = 1'b0;
    bus.ex_target_PC_out   = 32'h0;
    bus.if_stall           = 1'b0;
    bus.Imem2proc_ready    = 1'b0;
    bus.Imem2proc_valid    = 1'b0;
    bus.Imem2proc_data     = 32'h0;
    do_reset();

    // streaming with single-cycle memory
    repeat (12) step();

    // consumer stalled: queue fills to DEPTH and issue stops
    do_reset();
    stall_hold = 1'b1;
    repeat (6) step();
    chk("cmd_when_full", 32'(bus.proc2Imem_command), 32'(BUS_NONE));
    chk("accepts_while_stalled", 32'(accepts), 32'd4);
    stall_hold = 1'b0;
    repeat (10) step();

    // redirect with two fetches in flight
    lat_min = 2; lat_max = 2;
    repeat (8) step();
    step(1'b1, 32'h100);
    repeat (12) step();

    // redirect coinciding with a response and a pop, then a wrapping target
    lat_min = 1; lat_max = 1;
    repeat (8) step();
    step(1'b1, 32'h200);
    repeat (6) step();
    step(1'b1, 32'hFFFF_FFFA);
    repeat (8) step();

    // memory not ready for three cycles on the 0x8 request
    do_reset();
    repeat (2) step();
    rdy_pct = 0;
    repeat (3) step();
    rdy_pct = 100;
    repeat (8) step();

    // reset with responses outstanding
    lat_min = 3; lat_max = 3;
    repeat (5) step();
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (10) step();

    // random traffic
    lat_min = 1; lat_max = 4; rdy_pct = 70; stall_pct = 25;
    for (int i = 0; i < 1500; i++) begin
      if (i == 500 || i == 1000) begin
        do_reset();
        step();
      end
      rd = ($urandom_range(99) < 6);
      tg = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      step(rd, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
